// File: rtl/toggle_cover_queue.sv
// Toggle-coverage collector: per-bit hit pulses are held in a pending bitmap, scanned out
// lowest-index-first into a fall-through FIFO, and reported as global cover indices.
// Optional build macro TOGGLE_DEDUP_EN reports each point at most once per reset.
module toggle_cover_queue #(
  parameter int WIDTH       = 22,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 38253,
  parameter int FIFO_DEPTH  = 8,
  parameter int IDX_W       = 32
) (
  input  logic             gbl_clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] hit,
  input  logic             flush_req,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_index,
  output logic             flush_done,
  output logic             busy,
  output logic [15:0]      merge_cnt,
  output logic [15:0]      cover_cnt,
  output logic [1:0]       state_dbg
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (64'(COVER_INDEX) + 64'(WIDTH) > 64'(COVER_TOTAL) ||
      64'(COVER_TOTAL) > (64'd1 << IDX_W)) begin : g_bad_cfg
    $error("toggle_cover_queue: cover index range does not fit");
  end

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] pend, pend_next;
  logic [WIDTH-1:0] hit_new, acc;
  logic [WIDTH-1:0] sel_onehot, clear_mask, merge_bits;
  logic [SEL_W-1:0] sel_idx;
  logic [CNT_W-1:0] merge_pop;
  logic [16:0]      merge_sum;
  logic [15:0]      merge_next;

  logic [IDX_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, pop, can_push;
  logic [IDX_W-1:0] push_index;

`ifdef TOGGLE_DEDUP_EN
  logic [WIDTH-1:0] covered;

  assign hit_new = hit & ~covered;

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      covered <= '0;
    end else begin
      covered <= covered | acc;
    end
  end
`else
  assign hit_new = hit;
`endif

  assign acc = (sample_en && state == RUN) ? hit_new : '0;

  // Scan: lowest pending bit, as both a one-hot mask and a binary index.
  assign sel_onehot = pend & (~pend + WIDTH'(1));

  always_comb begin
    sel_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend[i]) sel_idx = SEL_W'(i);
    end
  end

  // Event port: evt_valid means evt_index holds the FIFO head; the entry is consumed on any
  // cycle with evt_valid && evt_ready, and the head is held stable while evt_ready is low.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign evt_valid = !empty;
  assign pop      = evt_valid && evt_ready;
  assign can_push = !full || pop;
  assign push     = (pend != '0) && can_push;
  assign push_index = IDX_W'(COVER_INDEX) + IDX_W'(sel_idx);
  assign evt_index = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign clear_mask = push ? sel_onehot : '0;
  assign pend_next  = (pend & ~clear_mask) | acc;
  // A re-hit on the bit leaving this cycle is a fresh event, so it is excluded from merges.
  assign merge_bits = acc & pend & ~clear_mask;

  always_comb begin
    merge_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      merge_pop = merge_pop + CNT_W'(merge_bits[i]);
    end
  end

  assign merge_sum  = {1'b0, merge_cnt} + 17'(merge_pop);
  assign merge_next = merge_sum[16] ? 16'hFFFF : merge_sum[15:0];

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      pend      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      merge_cnt <= '0;
      cover_cnt <= '0;
    end else begin
      pend      <= pend_next;
      merge_cnt <= merge_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (cover_cnt != 16'hFFFF) cover_cnt <= cover_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge gbl_clk) begin
    if (reset && push) mem[wr_ptr[AW-1:0]] <= push_index;
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    flush_done = 1'b0;
    case (state)
      RUN:     if (flush_req) state_next = DRAIN;
      DRAIN:   if (pend == '0 && empty) state_next = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign busy      = (pend != '0) | evt_valid;
  assign state_dbg = state;

endmodule

// File: tb/tb_toggle_cover_queue.sv
// Bench for toggle_cover_queue: table of single-cycle hit patterns plus hand-written stall,
// flush and reset sequences; emitted indices are checked against an expected queue.
module tb_toggle_cover_queue;

  localparam int WIDTH = 22;
  localparam int CI    = 100;
  localparam int DEPTH = 8;
  localparam int IDX_W = 32;

  logic             gbl_clk = 1'b0;
  logic             reset = 1'b0;
  logic             sample_en = 1'b0;
  logic [WIDTH-1:0] hit = '0;
  logic             flush_req = 1'b0;
  logic             evt_ready = 1'b0;
  logic             evt_valid;
  logic [IDX_W-1:0] evt_index;
  logic             flush_done;
  logic             busy;
  logic [15:0]      merge_cnt;
  logic [15:0]      cover_cnt;
  logic [1:0]       state_dbg;

  toggle_cover_queue #(
    .WIDTH(WIDTH), .COVER_INDEX(CI), .COVER_TOTAL(38253), .FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)
  ) dut (
    .gbl_clk(gbl_clk), .reset(reset), .sample_en(sample_en), .hit(hit),
    .flush_req(flush_req), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_index(evt_index), .flush_done(flush_done), .busy(busy),
    .merge_cnt(merge_cnt), .cover_cnt(cover_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 gbl_clk = ~gbl_clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [IDX_W-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] hit;
    logic             en;
    int               n_evt;
  } vec_t;

  vec_t vecs[7];

`ifdef TOGGLE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge gbl_clk);
      #1;
    end
  endtask

  task automatic do_reset;
    reset     = 1'b0;
    hit       = '0;
    sample_en = 1'b0;
    flush_req = 1'b0;
    evt_ready = 1'b0;
    exp_q.delete();
    tick(2);
    pops  = 0;
    reset = 1'b1;
  endtask

  task automatic pulse_hit(input logic [WIDTH-1:0] h);
    hit = h;
    tick(1);
    hit = '0;
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] h);
    for (int i = 0; i < WIDTH; i++) begin
      if (h[i]) exp_q.push_back(IDX_W'(CI + i));
    end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < bound) begin
      tick(1);
      n++;
    end
    chk(name, {31'd0, (busy || exp_q.size() != 0)}, 32'd0);
  endtask

  // scoreboard: compare every accepted event against the expected queue
  always @(negedge gbl_clk) begin
    if (reset && evt_valid && evt_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_evt: got index %0d, expected no event", evt_index);
      end else begin
        chk("evt_index", evt_index, exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int pop_at;

    vecs[0] = '{hit: 22'h000021, en: 1'b1, n_evt: 2};
    vecs[1] = '{hit: 22'h200000, en: 1'b1, n_evt: 1};
    vecs[2] = '{hit: 22'h3FFFFF, en: 1'b0, n_evt: 0};
    vecs[3] = '{hit: 22'h155555, en: 1'b1, n_evt: 11};
    vecs[4] = '{hit: 22'h3FFFFF, en: 1'b1, n_evt: 22};
    vecs[5] = '{hit: 22'h000000, en: 1'b1, n_evt: 0};
    vecs[6] = '{hit: 22'h2AAAAA, en: 1'b1, n_evt: 11};

    // reset release, idle for 10 cycles
    do_reset();
    sample_en = 1'b1;
    tick(10);
    chk("idle_valid", {31'd0, evt_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_merge", merge_cnt, 32'd0);
    chk("idle_cover", cover_cnt, 32'd0);
    chk("idle_flush_done", {31'd0, flush_done}, 32'd0);
    chk("idle_state", state_dbg, 32'd0);

    // minimum latency: sampled at edge t, visible after edge t+1
    do_reset();
    sample_en = 1'b1;
    evt_ready = 1'b1;
    push_exp(22'h000021);
    hit = 22'h000021;
    tick(1);
    hit = '0;
    chk("lat_t1_valid", {31'd0, evt_valid}, 32'd0);
    tick(1);
    chk("lat_t2_valid", {31'd0, evt_valid}, 32'd1);
    chk("lat_t2_index", evt_index, 32'd100);
    wait_idle("lat_idle", 50);
    chk("lat_cover", cover_cnt, 32'd2);

    // table of single-cycle patterns with the sink always ready
    for (int v = 0; v < 7; v++) begin
      do_reset();
      sample_en = vecs[v].en;
      evt_ready = 1'b1;
      if (vecs[v].en) push_exp(vecs[v].hit);
      pulse_hit(vecs[v].hit);
      wait_idle("vec_idle", 60);
      chk("vec_cover", cover_cnt, 32'(vecs[v].n_evt));
      chk("vec_merge", merge_cnt, 32'd0);
    end

    // FIFO fills and stalls; further hits merge into the pending bitmap
    do_reset();
    sample_en = 1'b1;
    if (DEDUP) begin
      push_exp(22'h3FFFFF);
    end else begin
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(IDX_W'(CI + i));
      push_exp(22'h3FFFFF);
    end
    pulse_hit(22'h3FFFFF);
    tick(12);
    chk("stall_cover", cover_cnt, 32'd8);
    chk("stall_valid", {31'd0, evt_valid}, 32'd1);
    chk("stall_head", evt_index, 32'd100);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    hit = 22'h3FFFFF;
    tick(2);
    hit = '0;
    chk("stall_merge", merge_cnt, DEDUP ? 32'd0 : 32'd36);
    chk("stall_cover_hold", cover_cnt, 32'd8);
    evt_ready = 1'b1;
    wait_idle("stall_idle", 200);
    chk("stall_cover_end", cover_cnt, DEDUP ? 32'd22 : 32'd30);

    // same point hit on five separate occasions
    do_reset();
    sample_en = 1'b1;
    evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!DEDUP || k == 0) exp_q.push_back(IDX_W'(CI + 3));
      pulse_hit(22'h000008);
      tick(5);
    end
    wait_idle("rehit_idle", 50);
    chk("rehit_cover", cover_cnt, DEDUP ? 32'd1 : 32'd5);
    chk("rehit_merge", merge_cnt, 32'd0);

    // flush with four queued events; a hit during DRAIN is ignored
    do_reset();
    sample_en = 1'b1;
    push_exp(22'h00000F);
    pulse_hit(22'h00000F);
    tick(6);
    chk("flush_pre_cover", cover_cnt, 32'd4);
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    chk("flush_state_drain", state_dbg, 32'd1);
    pulse_hit(22'h000001);
    tick(2);
    chk("flush_drain_cover", cover_cnt, 32'd4);
    evt_ready = 1'b1;
    pulses = 0;
    pop_at = -1;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (flush_done) begin
        pulses++;
        pop_at = pops;
      end
    end
    chk("flush_pulses", 32'(pulses), 32'd1);
    chk("flush_after_pops", 32'(pop_at), 32'd4);
    wait_idle("flush_idle", 20);
    chk("flush_state_run", state_dbg, 32'd0);
    chk("flush_cover", cover_cnt, 32'd4);

    // flush with nothing pending: done two cycles after the request
    do_reset();
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    chk("eflush_c1", {31'd0, flush_done}, 32'd0);
    tick(1);
    chk("eflush_c2", {31'd0, flush_done}, 32'd1);
    tick(1);
    chk("eflush_c3", {31'd0, flush_done}, 32'd0);
    chk("eflush_state", state_dbg, 32'd0);

    // reset mid-operation: three queued, one pending, in DRAIN
    do_reset();
    sample_en = 1'b1;
    hit = 22'h00000F;
    tick(1);
    hit = 22'h000008;
    tick(1);
    hit = '0;
    tick(2);
    chk("mid_cover", cover_cnt, 32'd3);
    chk("mid_merge", merge_cnt, DEDUP ? 32'd0 : 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    chk("mid_state_drain", state_dbg, 32'd1);
    reset = 1'b0;
    tick(1);
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cover", cover_cnt, 32'd0);
    chk("rst_merge", merge_cnt, 32'd0);
    chk("rst_state", state_dbg, 32'd0);
    chk("rst_index", evt_index, 32'd0);
    reset = 1'b1;
    tick(3);
    chk("rst_after_valid", {31'd0, evt_valid}, 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
